// File: rtl/avmm_read_responder.sv
// Avalon-MM read-only responder: DEPTH x DATA_WIDTH word array, one read in flight,
// fixed-latency return with waitrequest backpressure and a side load port.
module avmm_read_responder #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned LATENCY    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    address,
    input  logic                     read,
    output logic [DATA_WIDTH-1:0]    readdata,
    output logic                     readdatavalid,
    output logic                     waitrequest,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]    load_data,
    output logic                     err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        BUSY = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state, state_nx;
    logic [CNT_W-1:0]      lat_cnt, lat_cnt_nx;
    logic [DATA_WIDTH-1:0] cap_word, cap_word_nx;
    logic [DATA_WIDTH-1:0] readdata_nx;
    logic                  readdatavalid_nx;
    logic                  waitrequest_nx;
    logic                  err_nx;

    logic [IDX_W-1:0]      rd_idx_c;
    logic                  oor_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic                  accept_c;
    logic                  addr_lsb_unused;

    // Byte address -> word index; any set bit above the index field is out of range.
    assign rd_idx_c        = address[IDX_W+2:3];
    assign oor_c           = |address[ADDR_WIDTH-1:IDX_W+3];
    assign rd_word_c       = oor_c ? '0 : mem[rd_idx_c];
    assign accept_c        = read && !waitrequest;
    assign addr_lsb_unused = ^address[2:0];

    // Load port: writes in every state and is not affected by rst.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= INIT;
            lat_cnt       <= '0;
            cap_word      <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            waitrequest   <= 1'b1;
            err           <= 1'b0;
        end else begin
            state         <= state_nx;
            lat_cnt       <= lat_cnt_nx;
            cap_word      <= cap_word_nx;
            readdata      <= readdata_nx;
            readdatavalid <= readdatavalid_nx;
            waitrequest   <= waitrequest_nx;
            err           <= err_nx;
        end
    end

    // Response edge is the one on which lat_cnt reaches zero, i.e. LATENCY-1 edges after acceptance.
    always_comb begin
        state_nx         = state;
        lat_cnt_nx       = lat_cnt;
        cap_word_nx      = cap_word;
        readdata_nx      = readdata;
        readdatavalid_nx = 1'b0;
        waitrequest_nx   = waitrequest;
        err_nx           = err;

        case (state)
            INIT: begin
                state_nx       = IDLE;
                waitrequest_nx = 1'b0;
            end
            IDLE: begin
                waitrequest_nx = 1'b0;
                if (accept_c) begin
                    err_nx = err | oor_c;
                    if (LATENCY == 1) begin
                        readdata_nx      = rd_word_c;
                        readdatavalid_nx = 1'b1;
                    end else begin
                        cap_word_nx    = rd_word_c;
                        lat_cnt_nx     = CNT_W'(LATENCY - 1);
                        waitrequest_nx = 1'b1;
                        state_nx       = BUSY;
                    end
                end
            end
            BUSY: begin
                waitrequest_nx = 1'b1;
                lat_cnt_nx     = lat_cnt - CNT_W'(1);
                if (lat_cnt == CNT_W'(1)) begin
                    readdata_nx      = cap_word;
                    readdatavalid_nx = 1'b1;
                    waitrequest_nx   = 1'b0;
                    state_nx         = IDLE;
                end
            end
            default: begin
                state_nx = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_avmm_read_responder.sv
// Scoreboard bench for avmm_read_responder: index 0 is a LATENCY=3 instance, index 1 LATENCY=1.
module tb_avmm_read_responder;

    logic        clk;
    logic        rst           [2];
    logic [31:0] address       [2];
    logic        read          [2];
    logic [63:0] readdata      [2];
    logic        readdatavalid [2];
    logic        waitrequest   [2];
    logic        load_en       [2];
    logic [7:0]  load_addr     [2];
    logic [63:0] load_data     [2];
    logic        err           [2];

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;

    int cyc;
    int checks;
    int errors;

    avmm_read_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(256), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst[0]), .address(address[0]), .read(read[0]),
        .readdata(readdata[0]), .readdatavalid(readdatavalid[0]), .waitrequest(waitrequest[0]),
        .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0]), .err(err[0])
    );

    avmm_read_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(256), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .address(address[1]), .read(read[1]),
        .readdata(readdata[1]), .readdatavalid(readdatavalid[1]), .waitrequest(waitrequest[1]),
        .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic int sb_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic sb_push(input int d, input logic [63:0] data, input int due);
        exp_t e;
        e.data = data;
        e.due  = due;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic sb_clear(input int d);
        if (d == 0) sb0.delete();
        else        sb1.delete();
    endtask

    // Every valid strobe must match the oldest pending expectation, in data and in cycle.
    always @(negedge clk) begin
        if (readdatavalid[0] === 1'b1) begin
            if (sb0.size() == 0) begin
                check_eq("rdv3_unexpected", 64'(readdatavalid[0]), 64'(0));
            end else begin
                e0 = sb0.pop_front();
                check_eq("rdata3", readdata[0], e0.data);
                check_eq("rdv3_cycle", 64'(cyc), 64'(e0.due));
            end
        end
        if (readdatavalid[1] === 1'b1) begin
            if (sb1.size() == 0) begin
                check_eq("rdv1_unexpected", 64'(readdatavalid[1]), 64'(0));
            end else begin
                e1 = sb1.pop_front();
                check_eq("rdata1", readdata[1], e1.data);
                check_eq("rdv1_cycle", 64'(cyc), 64'(e1.due));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int d, input logic [7:0] idx, input logic [63:0] data);
        load_en[d]   = 1'b1;
        load_addr[d] = idx;
        load_data[d] = data;
        @(posedge clk);
        #1;
        load_en[d] = 1'b0;
    endtask

    // Presents a read, waits for it to be accepted, records expected data and arrival cycle.
    task automatic do_read(input int d, input logic [31:0] a, input logic [63:0] exp,
                           input bit keep, output int acc);
        int n;
        address[d] = a;
        read[d]    = 1'b1;
        n = 0;
        acc = -1;
        do begin
            @(negedge clk);
            n++;
        end while (waitrequest[d] !== 1'b0 && n < 50);
        if (waitrequest[d] !== 1'b0) begin
            check_eq("accept_timeout", 64'(waitrequest[d]), 64'(0));
            read[d] = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            sb_push(d, exp, cyc + lat(d));
            acc = cyc + 1;
            @(posedge clk);
            #1;
            if (!keep) read[d] = 1'b0;
        end
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (sb_size(d) > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb_size(d) > 0) begin
            check_eq("drain_timeout", 64'(sb_size(d)), 64'(0));
            sb_clear(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, prev;
        cyc    = 0;
        checks = 0;
        errors = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            address[d]   = '0;
            read[d]      = 1'b0;
            load_en[d]   = 1'b0;
            load_addr[d] = '0;
            load_data[d] = '0;
        end

        // Reset / init
        @(negedge clk);
        check_eq("rst_wr", 64'(waitrequest[0]), 64'(1));
        check_eq("rst_rdv", 64'(readdatavalid[0]), 64'(0));
        check_eq("rst_err", 64'(err[0]), 64'(0));
        check_eq("rst_rdata", readdata[0], 64'(0));
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        check_eq("init_wr", 64'(waitrequest[0]), 64'(1));
        @(negedge clk);
        check_eq("idle_wr", 64'(waitrequest[0]), 64'(0));
        check_eq("idle_wr_l1", 64'(waitrequest[1]), 64'(0));
        check_eq("idle_err", 64'(err[0]), 64'(0));
        @(posedge clk);
        #1;

        // Single read, waitrequest profile while busy, data holds afterwards
        load(0, 8'd5, 64'hDEADBEEF_01234567);
        do_read(0, 32'h28, 64'hDEADBEEF_01234567, 1'b0, acc);
        @(negedge clk);
        check_eq("busy_wr_a", 64'(waitrequest[0]), 64'(1));
        @(negedge clk);
        check_eq("busy_wr_b", 64'(waitrequest[0]), 64'(1));
        @(negedge clk);
        check_eq("resp_wr", 64'(waitrequest[0]), 64'(0));
        check_eq("resp_rdv", 64'(readdatavalid[0]), 64'(1));
        cycles(3);
        @(negedge clk);
        check_eq("hold_rdata", readdata[0], 64'hDEADBEEF_01234567);
        check_eq("hold_rdv", 64'(readdatavalid[0]), 64'(0));
        @(posedge clk);
        #1;

        // Back-to-back reads with read held high
        for (int i = 0; i < 4; i++) load(0, 8'(i), 64'(16 + i));
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            do_read(0, 32'(i * 8), 64'(16 + i), i < 3, acc);
            if (i > 0) check_eq("b2b_gap", 64'(acc - prev), 64'(3));
            prev = acc;
        end
        drain(0);

        // Misaligned and out-of-range
        do_read(0, 32'h2F, 64'hDEADBEEF_01234567, 1'b0, acc);
        drain(0);
        @(negedge clk);
        check_eq("err_clear", 64'(err[0]), 64'(0));
        @(posedge clk);
        #1;
        do_read(0, 32'h800, 64'(0), 1'b0, acc);
        @(negedge clk);
        check_eq("err_set", 64'(err[0]), 64'(1));
        repeat (10) @(negedge clk);
        check_eq("err_sticky", 64'(err[0]), 64'(1));
        @(posedge clk);
        #1;
        drain(0);
        do_read(0, 32'h10, 64'h12, 1'b0, acc);
        drain(0);

        // Load/read collision and load during BUSY
        load(0, 8'd7, 64'h55);
        load_en[0]   = 1'b1;
        load_addr[0] = 8'd7;
        load_data[0] = 64'hAA;
        do_read(0, 32'h38, 64'h55, 1'b0, acc);
        load_en[0] = 1'b0;
        drain(0);
        do_read(0, 32'h38, 64'hAA, 1'b0, acc);
        load(0, 8'd7, 64'hBB);
        drain(0);
        do_read(0, 32'h38, 64'hBB, 1'b0, acc);
        drain(0);

        // Reset one edge after acceptance aborts the read
        do_read(0, 32'h28, 64'hDEADBEEF_01234567, 1'b0, acc);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        sb_clear(0);
        cycles(8);
        @(negedge clk);
        check_eq("rst_clears_err", 64'(err[0]), 64'(0));
        @(posedge clk);
        #1;
        do_read(0, 32'h18, 64'h13, 1'b0, acc);
        drain(0);

        // Reset on the response edge drops the response
        do_read(0, 32'h08, 64'h11, 1'b0, acc);
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        sb_clear(0);
        cycles(8);
        do_read(0, 32'h00, 64'h10, 1'b0, acc);
        drain(0);

        // LATENCY=1: response in the cycle after acceptance, one read per cycle
        for (int i = 0; i < 3; i++) load(1, 8'(i), 64'hA0 + 64'(i));
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            do_read(1, 32'(i * 8), 64'hA0 + 64'(i), i < 2, acc);
            if (i > 0) check_eq("l1_gap", 64'(acc - prev), 64'(1));
            prev = acc;
        end
        drain(1);
        address[1] = 32'h08;
        read[1]    = 1'b1;
        rst[1]     = 1'b1;
        @(posedge clk);
        #1;
        rst[1]  = 1'b0;
        read[1] = 1'b0;
        cycles(5);
        do_read(1, 32'h10, 64'hA2, 1'b0, acc);
        drain(1);

        cycles(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
